// File: rtl/mmio_uart_tx_responder_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register word
// offsets, STATUS bit positions, transmit FSM encoding and the bus request.
package mmio_uart_tx_responder_pkg;

  // Word offsets, taken from Address[3:2]
  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] DIV_OFS    = 2'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSY    = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } busReq_t;

endpackage

// File: rtl/mmio_uart_tx_responder_fifo.sv
// Byte FIFO feeding the serial transmitter; pointers wrap modulo DEPTH and
// the occupancy is kept in its own counter so full and empty are unambiguous.
module tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // When full, a push lands on the slot being popped; rdata is sampled first.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= wdata;
  end

  assign rdata = mem[rdPtr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);

endmodule

// File: rtl/mmio_uart_tx_responder.sv
// Memory-bus responder beside Memoria: TX FIFO, STATUS and DIV registers,
// and an 8N1 serial transmitter with a registered output line.
module mmio_uart_tx_responder
  import mmio_uart_tx_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  busReq_t req;
  assign req = '{addr: Address, wr: Wr, data: Datain};

  logic [1:0] ofs;
  logic       wrEn, pushReq, pushAcc, pop, empty, full;
  logic [7:0] rdata;
  logic [CW-1:0] count;

  assign ofs     = req.addr[3:2];
  assign hit     = req.addr[31:4] == BASE_ADDR[31:4];
  assign wrEn    = hit && req.wr;
  assign pushReq = wrEn && (ofs == TXDATA_OFS);
  assign pushAcc = pushReq && (!full || pop);

  logic unused;
  assign unused = ^{req.addr[1:0], req.data[31:16]};

  tx_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clock(clock), .reset(reset), .push(pushAcc), .pop(pop),
    .wdata(req.data[7:0]), .rdata(rdata), .empty(empty), .full(full), .count(count)
  );

  txState_t    state, stateN;
  logic [15:0] baudCnt, baudN, div, baudLoad;
  logic [2:0]  bitIdx, bitN;
  logic [7:0]  shift, shiftN;
  logic        txReg, txN, overflow;

  assign baudLoad = div - 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitIdx  <= '0;
      shift   <= '0;
      txReg   <= 1'b1;
    end else begin
      state   <= stateN;
      baudCnt <= baudN;
      bitIdx  <= bitN;
      shift   <= shiftN;
      txReg   <= txN;
    end
  end

  // txN tracks the level of the state being entered, so tx is a clean flop.
  always_comb begin
    stateN = state;
    baudN  = baudCnt;
    bitN   = bitIdx;
    shiftN = shift;
    txN    = txReg;
    pop    = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1; shiftN = rdata; baudN = baudLoad; stateN = START; txN = 1'b0;
      end
      START: if (baudCnt == '0) begin
        stateN = DATA; bitN = '0; baudN = baudLoad; txN = shift[0];
      end else baudN = baudCnt - 16'd1;
      DATA: if (baudCnt == '0) begin
        baudN = baudLoad;
        if (bitIdx == 3'd7) begin
          stateN = STOP; txN = 1'b1;
        end else begin
          shiftN = {1'b0, shift[7:1]}; bitN = bitIdx + 3'd1; txN = shift[1];
        end
      end else baudN = baudCnt - 16'd1;
      STOP: if (baudCnt == '0) begin
        if (!empty) begin
          pop = 1'b1; shiftN = rdata; baudN = baudLoad; stateN = START; txN = 1'b0;
        end else begin
          stateN = IDLE; txN = 1'b1;
        end
      end else baudN = baudCnt - 16'd1;
      default: ;
    endcase
  end

  assign tx      = txReg;
  assign tx_busy = state != IDLE;

  logic [31:0] status, rdVal;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = overflow;
    status[ST_BUSY]  = tx_busy;
    status[ST_CNT_MSB:ST_CNT_LSB] = 7'(count);
    case (ofs)
      STATUS_OFS: rdVal = status;
      DIV_OFS:    rdVal = {16'd0, div};
      default:    rdVal = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div      <= 16'(DEFAULT_DIV);
      overflow <= 1'b0;
      Dataout  <= '0;
    end else begin
      if (wrEn && ofs == DIV_OFS)
        div <= (req.data[15:0] == 16'd0) ? 16'd1 : req.data[15:0];
      if (pushReq && !pushAcc)
        overflow <= 1'b1;
      else if (wrEn && ofs == STATUS_OFS && req.data[ST_OVF])
        overflow <= 1'b0;
      Dataout <= (hit && !req.wr) ? rdVal : '0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx_responder.sv
// Bench for mmio_uart_tx_responder: a queue/frame-level reference model checked
// every cycle, plus directed literal checks of frames and register reads.
module tb_mmio_uart_tx_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] NOHIT = 32'h0000_1000;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0, reset = 1'b0, Wr = 1'b0;
  logic [31:0] Address = NOHIT, Datain = 32'd0;
  logic [31:0] Dataout;
  logic        hit, tx, tx_busy;
  int          nCmp = 0, nBad = 0;

  mmio_uart_tx_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16)) dut (
    .clock(clock), .reset(reset), .Address(Address), .Wr(Wr), .Datain(Datain),
    .Dataout(Dataout), .hit(hit), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clock = ~clock;

  // Reference model: FIFO as a queue, the line as a 10-bit frame where each
  // bit lasts the divisor in force when that bit began.
  logic [7:0]  q[$];
  logic        mOvf = 1'b0, mBusy = 1'b0;
  logic [9:0]  mBits = '1;
  int          mDiv = 16, mBitNo = 0, mLeft = 0;
  logic [31:0] eDout = 32'd0;

  function automatic logic [31:0] regVal(input logic [31:0] a);
    logic [31:0] st;
    st = {17'd0, 7'(q.size()), 4'd0, mBusy, mOvf, q.size() == DEPTH, q.size() == 0};
    case (a[3:2])
      2'd1:    return st;
      2'd2:    return 32'(mDiv);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    logic       mHit, popNow;
    logic [7:0] b;
    if (!reset) begin
      q.delete(); mOvf = 1'b0; mDiv = 16; mBusy = 1'b0; mBits = '1;
      mBitNo = 0; mLeft = 0; eDout = 32'd0;
    end else begin
      mHit   = Address[31:4] == BASE[31:4];
      eDout  = (mHit && !Wr) ? regVal(Address) : 32'd0;
      popNow = (q.size() != 0) && (!mBusy || (mBitNo == 9 && mLeft == 1));
      if (mBusy) begin
        if (mLeft > 1) mLeft--;
        else if (mBitNo < 9) begin mBitNo++; mLeft = mDiv; end
        else mBusy = 1'b0;
      end
      if (popNow) begin
        b = q.pop_front();
        mBits = {1'b1, b, 1'b0}; mBitNo = 0; mLeft = mDiv; mBusy = 1'b1;
      end
      if (mHit && Wr) begin
        case (Address[3:2])
          2'd0: if (q.size() < DEPTH) q.push_back(Datain[7:0]); else mOvf = 1'b1;
          2'd1: if (Datain[2]) mOvf = 1'b0;
          2'd2: mDiv = (Datain[15:0] == 16'd0) ? 1 : int'(Datain[15:0]);
          default: ;
        endcase
      end
    end
  end

  task automatic cmpAll();
    logic eTx, eHit;
    eTx  = mBusy ? mBits[mBitNo] : 1'b1;
    eHit = Address[31:4] == BASE[31:4];
    nCmp += 4;
    if (tx !== eTx) begin nBad++; $display("FAIL tx t=%0t got %b want %b", $time, tx, eTx); end
    if (tx_busy !== mBusy) begin nBad++; $display("FAIL tx_busy t=%0t got %b want %b", $time, tx_busy, mBusy); end
    if (Dataout !== eDout) begin nBad++; $display("FAIL Dataout t=%0t got %h want %h", $time, Dataout, eDout); end
    if (hit !== eHit) begin nBad++; $display("FAIL hit t=%0t got %b want %b", $time, hit, eHit); end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin nBad++; $display("FAIL %s got %h want %h", nm, act, exp); end
  endtask

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; Wr = 1'b1; Datain = d;
    tick();
    Wr = 1'b0; Address = NOHIT; Datain = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    Address = a; Wr = 1'b0;
    tick();
    v = Dataout; Address = NOHIT;
  endtask

  initial begin
    logic [31:0] v;
    logic [19:0] cap;
    int k;
    fork
      forever begin @(negedge clock); cmpAll(); end
    join_none

    // reset, then reset asserted mid-frame
    repeat (3) tick();
    reset = 1'b1;
    rd(BASE + 4, v); chk("rst_status", v, 32'h1);
    rd(BASE + 8, v); chk("rst_div", v, 32'd16);
    wr(BASE + 8, 32'd4);
    wr(BASE, 32'h55);
    repeat (10) tick();
    chk("busy_midframe", tx_busy, 1);
    #1 reset = 1'b0; #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", tx_busy, 0);
    chk("async_rst_dout", Dataout, 0);
    tick(); tick();
    reset = 1'b1;
    rd(BASE + 4, v); chk("rst2_status", v, 32'h1);
    rd(BASE + 8, v); chk("rst2_div", v, 32'd16);

    // single byte 0xA5 at div 2
    wr(BASE + 8, 32'd2);
    wr(BASE, 32'hA5);
    chk("pre_frame_tx", tx, 1);
    tick();
    for (int i = 0; i < 20; i++) begin cap[i] = tx; tick(); end
    chk("frame_a5", 32'(cap), 32'h000F30CC);
    chk("busy_after_a5", tx_busy, 0);

    // back-to-back frames at div 1
    wr(BASE + 8, 32'd1);
    wr(BASE, 32'h01);
    wr(BASE, 32'h02);
    for (int i = 0; i < 20; i++) begin cap[i] = tx; tick(); end
    chk("frames_01_02", 32'(cap), 32'h00081202);
    chk("busy_after_b2b", tx_busy, 0);

    // overflow at depth 8
    wr(BASE + 8, 32'd100);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h10 + 32'(i));
    rd(BASE + 4, v); chk("ovf_status", v, 32'h0000_080E);
    wr(BASE + 4, 32'h4);
    rd(BASE + 4, v); chk("ovf_cleared", v, 32'h0000_080A);

    // push while full on the cycle the FSM pops
    k = 0;
    while (!(mBusy && mBitNo == 9 && mLeft == 1) && k < 3000) begin tick(); k++; end
    chk("pop_edge_found", 32'(k < 3000), 32'd1);
    wr(BASE, 32'h77);
    rd(BASE + 4, v); chk("full_pop_push", v, 32'h0000_080A);
    wr(BASE + 8, 32'd1);
    k = 0;
    while (tx_busy && k < 20000) begin tick(); k++; end
    chk("drained", tx_busy, 0);
    rd(BASE + 4, v); chk("drained_status", v, 32'h1);

    // decode and read timing
    Address = BASE + 12; #1; chk("hit_reserved", hit, 1);
    rd(BASE + 12, v); chk("rd_reserved", v, 0);
    wr(BASE + 12, 32'hFFFF_FFFF);
    rd(BASE + 5, v); chk("rd_status_alias", v, 32'h1);
    Address = 32'hFFFF_FE08; #1; chk("hit_near_miss", hit, 0);
    wr(32'hFFFF_FE08, 32'd5);
    rd(BASE + 8, v); chk("nohit_write_ignored", v, 32'd1);
    rd(NOHIT, v); chk("rd_nohit", v, 0);
    wr(BASE + 8, 32'd7);
    rd(BASE + 8, v); chk("div_7", v, 32'd7);
    wr(BASE + 8, 32'd0);
    rd(BASE + 10, v); chk("div_zero_as_one", v, 32'd1);
    rd(BASE, v); chk("rd_txdata", v, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx_responder.md
Name: mmio_uart_tx_responder

Overview:
- Memory-bus responder that sits beside Memoria on the CPU's memory bus.
- Uses the same Address / Wr / Datain / Dataout signalling and the same one-cycle registered read timing, so the CPU talks to it exactly as it talks to memory.
- Provides a memory-mapped serial transmitter: the CPU stores bytes into a TX FIFO, and the block drains them as 8N1 frames on a single output line.
- The top level muxes Dataout between Memoria and this block using the hit output.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, base of the 16-byte register window; bits [3:0] must be zero.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..64.
- DEFAULT_DIV, 16, clock cycles per serial bit after reset.

Ports:
- clock, in, 1, system clock; all state changes on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- Address, in, 32, byte address from the CPU address mux.
- Wr, in, 1, 1 = write cycle, 0 = read cycle.
- Datain, in, 32, store data from the CPU.
- Dataout, out, 32, registered read data.
- hit, out, 1, combinational: Address[31:4] == BASE_ADDR[31:4].
- tx, out, 1, serial line; idles high.
- tx_busy, out, 1, high while a frame is on the line.

Behaviour:
- Reset (reset = 0, asynchronous, effective immediately, including mid-frame):
  - FIFO empty (read pointer, write pointer and count = 0); overflow = 0.
  - div = DEFAULT_DIV; FSM in IDLE.
  - tx = 1, tx_busy = 0, Dataout = 0.
- Register map (offset = Address[3:0]):
  - 0x0 TXDATA, write-only; reads return 0.
  - 0x4 STATUS, read; writes are write-1-to-clear on bit 2.
  - 0x8 DIV, read/write, bits [15:0].
  - 0xC reserved; reads return 0, writes are ignored.
  - Address[1:0] is ignored, so byte offsets alias to their word.
- STATUS fields:
  - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 tx_busy.
  - bits [14:8] count, zero-extended.
  - all other bits 0.
- Writes (hit = 1 and Wr = 1, sampled at the clock edge):
  - TXDATA pushes Datain[7:0]. The push is accepted if count < FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1.
  - DIV loads Datain[15:0]; a written value of 0 is stored as 1. The new value applies from the next baud-counter reload; the current bit period is not shortened.
  - STATUS with Datain[2] = 1 clears overflow. If a clear and an overflowing push land in the same cycle, the set wins.
- Reads (Wr = 0):
  - Dataout <= register value when hit, else 0, every clock.
  - Read latency is 1 cycle, matching Memoria.
  - STATUS reflects state before the edge on which it is sampled.
  - On a write cycle, Dataout <= 0.
- Transmit FSM, states IDLE, START, DATA, STOP. The baud counter counts from div-1 down to 0.
  - IDLE: tx = 1. If the FIFO is not empty: pop into an 8-bit shift register, load the baud counter, go to START.
  - START: tx = 0 for div cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Every div cycles, shift right and increment the index. After bit 7's period, go to STOP.
  - STOP: tx = 1 for div cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame length is exactly 10*div cycles.
  - tx_busy = 1 in START, DATA and STOP.
  - tx is driven from a flop (glitch-free).
- FIFO:
  - Pointers are log2(FIFO_DEPTH) bits, wrap modulo the depth; count is a separate register.
  - Pop never occurs when empty.
  - A simultaneous push and pop leaves count unchanged.
- Non-hit addresses have no side effects.

Decomposition:
- Shared package: register offsets (TXDATA_OFS, STATUS_OFS, DIV_OFS), STATUS bit-position constants, FSM state encoding (2-bit typedef).
- One sub-module: tx_fifo (parameterised depth; push, pop, wdata, rdata, empty, full, count).
- The serial FSM, baud counter and bus decode stay in the top module.

Test Plan:
- Reset check: assert reset = 0 mid-frame with div = 4 -> tx = 1 within the same cycle; after release, a STATUS read returns 0x0000_0001 and a DIV read returns 16.
- Single byte: write DIV = 2, then TXDATA = 0xA5 -> tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 2 cycles wide (20 cycles total); tx_busy falls right after.
- Back-to-back: push 0x01 and 0x02 with div = 1 -> two frames with no idle cycle between the stop bit and the second start bit.
- Full/overflow: with div = 100, push 10 bytes at depth 8 -> 1 popped + 8 stored accepted, 1 dropped; STATUS bit1 = 1, bit2 = 1, count = 8. Writing STATUS = 0x4 clears bit2 only.
- Push on full during pop: fill the FIFO, then time a push on the cycle the FSM pops -> push accepted, overflow stays 0, count stays 8.
- Read timing and decode: read STATUS at BASE+4 -> value appears on Dataout the following cycle. Read BASE+0xC or a non-hit address -> Dataout = 0 and hit behaves accordingly. DIV write of 0 reads back as 1.
